core_controller: RTL and testbench
==================================

Name: core_controller

Overview:
- Per-core instruction sequencer for the Small_GPU core.
- Drives fetch from instruction memory and latches each 16-bit instruction into the instruction register feeding the decoder.
- Uses decoder opcode/immediate outputs to step execute, memory and writeback phases; issues enables to the ALU, register file and data-memory port.
- One instruction in flight; no pipelining.

Parameters:
- PC_WIDTH, 8, program counter width (instruction word address).
- OP_LDR, 4'hC, opcode for data-memory load.
- OP_STR, 4'hD, opcode for data-memory store.
- OP_BRZ, 4'hE, opcode for branch-if-zero; target = immediate.
- OP_HALT, 4'hF, opcode that stops the core.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  launch pulse; sampled only in IDLE.
- start_pc  input  PC_WIDTH  PC loaded on start.
- imem_req  output  1  instruction fetch request.
- imem_addr  output  PC_WIDTH  fetch address (= pc).
- imem_valid  input  1  fetch data valid.
- imem_rdata  input  `DATA_WIDTH  fetched instruction.
- instr  output  `DATA_WIDTH  instruction register, wired to decoder.
- opcode  input  4  from decoder.
- immediate  input  8  from decoder.
- zero_flag  input  1  ALU zero result of previous instruction.
- alu_en  output  1  one-cycle execute strobe.
- mem_req  output  1  data-memory request.
- mem_we  output  1  1 = store, 0 = load; valid with mem_req.
- mem_ready  input  1  data-memory completion.
- reg_we  output  1  one-cycle register-file write strobe.
- pc  output  PC_WIDTH  current program counter.
- busy  output  1  high in every state except IDLE/HALTED.
- done  output  1  high while HALTED.

Behaviour:
- Reset (async, any state, including mid-fetch or mid-memory-wait): state = IDLE; pc = 0; instr = 0; all strobes/requests = 0; busy = 0; done = 0. Outstanding memory responses after reset are ignored.
- State encoding: IDLE, FETCH, DECODE, EXECUTE, MEM_WAIT, WRITEBACK, HALTED. All outputs registered.
- IDLE: on start, pc <= start_pc and go to FETCH.
- FETCH:
  - imem_req = 1 and imem_addr = pc, held until imem_valid.
  - On imem_valid: instr <= imem_rdata, imem_req drops the next cycle, go to DECODE.
  - imem_valid in the same cycle the request is first raised is accepted.
- DECODE: one cycle; decoder outputs settle. Next state by opcode:
  - OP_HALT -> HALTED.
  - OP_BRZ -> if zero_flag then pc <= immediate (zero-extended/truncated to PC_WIDTH), else pc <= pc+1; then FETCH. No alu_en, no reg_we.
  - OP_LDR -> MEM_WAIT with mem_req = 1, mem_we = 0.
  - OP_STR -> MEM_WAIT with mem_req = 1, mem_we = 1.
  - Any other opcode -> EXECUTE.
- EXECUTE: alu_en = 1 for exactly one cycle, then WRITEBACK.
- MEM_WAIT:
  - mem_req held until mem_ready is sampled high, then deasserted.
  - Load -> WRITEBACK.
  - Store -> pc <= pc+1, FETCH (no reg_we).
- WRITEBACK: reg_we = 1 for one cycle; pc <= pc+1; go to FETCH.
- PC arithmetic: modulo 2^PC_WIDTH; pc = all-ones increments to 0 silently.
- Latency, ALU op with zero-wait memory: FETCH 1 + DECODE 1 + EXECUTE 1 + WRITEBACK 1 = 4 cycles/instruction. Each wait cycle adds one.
- HALTED: done = 1, busy = 0, pc frozen at the HALT address. A start pulse restarts (pc <= start_pc, FETCH, done drops).
- start while busy: ignored.
- zero_flag is sampled only in DECODE of OP_BRZ.

Optional Feature:
- Macro CTRL_PERF_CNT_EN.
- Defined:
  - Adds output retired_cnt (16 bits): increments by 1 at every WRITEBACK exit, completed store, taken/untaken branch, and HALT entry. Saturates at 16'hFFFF.
  - Adds output stall_cnt (16 bits): increments each cycle in FETCH with imem_valid=0 or in MEM_WAIT with mem_ready=0. Saturates at 16'hFFFF.
  - Both counters clear on rst and on start accepted.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- ALU program: start_pc=0x10; imem returns 16'h1123 with zero wait -> alu_en pulses at cycle 3 after start, reg_we at cycle 4, pc=0x11 at cycle 5.
- Branch: instr 16'hE040 with zero_flag=1 -> pc=0x40, no alu_en/reg_we. Repeat with zero_flag=0 -> pc = old pc+1.
- Memory wait: OP_LDR, mem_ready delayed 3 cycles -> mem_req held 4 cycles, mem_we=0, single reg_we. OP_STR -> mem_we=1, no reg_we.
- Halt/restart: 16'hF000 -> done=1, busy=0, pc stays. start with start_pc=0 -> done=0, fetch at 0.
- Reset mid-MEM_WAIT: rst asserted asynchronously -> mem_req=0, pc=0, state IDLE immediately; a late mem_ready causes no reg_we.
- Wrap + perf (CTRL_PERF_CNT_EN): pc=0xFF ALU op -> pc=0x00. Three instructions with 2 fetch-stall cycles -> retired_cnt=3, stall_cnt=2.

Source files
------------

// File: rtl/core_controller.sv
// Per-core instruction sequencer: fetch, decode, execute, memory wait and writeback with registered outputs.
// Optional performance counters are enabled with `define CTRL_PERF_CNT_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module core_controller #(
  parameter int unsigned PC_WIDTH = 8,
  parameter logic [3:0]  OP_LDR   = 4'hC,
  parameter logic [3:0]  OP_STR   = 4'hD,
  parameter logic [3:0]  OP_BRZ   = 4'hE,
  parameter logic [3:0]  OP_HALT  = 4'hF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [PC_WIDTH-1:0]    start_pc,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_valid,
  input  logic [`DATA_WIDTH-1:0] imem_rdata,
  output logic [`DATA_WIDTH-1:0] instr,
  input  logic [3:0]             opcode,
  input  logic [7:0]             immediate,
  input  logic                   zero_flag,
  output logic                   alu_en,
  output logic                   mem_req,
  output logic                   mem_we,
  input  logic                   mem_ready,
  output logic                   reg_we,
  output logic [PC_WIDTH-1:0]    pc,
`ifdef CTRL_PERF_CNT_EN
  output logic [15:0]            retired_cnt,
  output logic [15:0]            stall_cnt,
`endif
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExecute,
    StMemWait,
    StWriteback,
    StHalted
  } state_e;

  state_e state;

  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] imm_pc;

  assign pc_inc    = pc + PC_WIDTH'(1);
  assign imm_pc    = PC_WIDTH'(immediate);
  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= StIdle;
      pc       <= '0;
      instr    <= '0;
      imem_req <= 1'b0;
      alu_en   <= 1'b0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      reg_we   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      alu_en <= 1'b0;
      reg_we <= 1'b0;
      case (state)
        StIdle, StHalted: begin
          if (start) begin
            pc       <= start_pc;
            state    <= StFetch;
            imem_req <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
          end
        end
        StFetch: begin
          if (imem_valid) begin
            instr    <= imem_rdata;
            imem_req <= 1'b0;
            state    <= StDecode;
          end
        end
        StDecode: begin
          if (opcode == OP_HALT) begin
            state <= StHalted;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (opcode == OP_BRZ) begin
            pc       <= zero_flag ? imm_pc : pc_inc;
            state    <= StFetch;
            imem_req <= 1'b1;
          end else if (opcode == OP_LDR || opcode == OP_STR) begin
            mem_req <= 1'b1;
            mem_we  <= (opcode == OP_STR);
            state   <= StMemWait;
          end else begin
            alu_en <= 1'b1;
            state  <= StExecute;
          end
        end
        StExecute: begin
          reg_we <= 1'b1;
          state  <= StWriteback;
        end
        StMemWait: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            // mem_we still holds the store/load kind of this access
            if (mem_we) begin
              pc       <= pc_inc;
              state    <= StFetch;
              imem_req <= 1'b1;
            end else begin
              reg_we <= 1'b1;
              state  <= StWriteback;
            end
          end
        end
        StWriteback: begin
          pc       <= pc_inc;
          state    <= StFetch;
          imem_req <= 1'b1;
        end
        default: state <= StIdle;
      endcase
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic start_acc;
  logic retire_evt;
  logic stall_evt;

  assign start_acc  = (state == StIdle || state == StHalted) && start;
  assign retire_evt = (state == StWriteback) ||
                      (state == StMemWait && mem_ready && mem_we) ||
                      (state == StDecode && (opcode == OP_BRZ || opcode == OP_HALT));
  assign stall_evt  = (state == StFetch && !imem_valid) || (state == StMemWait && !mem_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else if (start_acc) begin
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (retire_evt && retired_cnt != 16'hFFFF) retired_cnt <= retired_cnt + 16'd1;
      if (stall_evt && stall_cnt != 16'hFFFF)    stall_cnt   <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_core_controller.sv
// Directed self-checking bench for core_controller; decoder modelled as instr[15:12]/instr[7:0].
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module tb_core_controller;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic [7:0]             start_pc;
  logic                   imem_req;
  logic [7:0]             imem_addr;
  logic                   imem_valid;
  logic [`DATA_WIDTH-1:0] imem_rdata;
  logic [`DATA_WIDTH-1:0] instr;
  logic [3:0]             opcode;
  logic [7:0]             immediate;
  logic                   zero_flag;
  logic                   alu_en;
  logic                   mem_req;
  logic                   mem_we;
  logic                   mem_ready;
  logic                   reg_we;
  logic [7:0]             pc;
  logic                   busy;
  logic                   done;
`ifdef CTRL_PERF_CNT_EN
  logic [15:0]            retired_cnt;
  logic [15:0]            stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign opcode    = instr[15:12];
  assign immediate = instr[7:0];

  core_controller dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_pc   (start_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .opcode     (opcode),
    .immediate  (immediate),
    .zero_flag  (zero_flag),
    .alu_en     (alu_en),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_ready  (mem_ready),
    .reg_we     (reg_we),
    .pc         (pc),
`ifdef CTRL_PERF_CNT_EN
    .retired_cnt(retired_cnt),
    .stall_cnt  (stall_cnt),
`endif
    .busy       (busy),
    .done       (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_pc = 8'h00; imem_valid = 1'b0;
    imem_rdata = '0; zero_flag = 1'b0; mem_ready = 1'b0;
    #12;
    chk ("rst_pc", {8'h00, pc}, 16'h0000);
    chk ("rst_instr", instr, 16'h0000);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_done", done, 1'b0);
    chkb("rst_imem_req", imem_req, 1'b0);
    chkb("rst_mem_req", mem_req, 1'b0);
    chkb("rst_alu_en", alu_en, 1'b0);
    chkb("rst_reg_we", reg_we, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ALU op, zero-wait fetch
    start_pc = 8'h10; start = 1'b1; imem_valid = 1'b1; imem_rdata = 16'h1123;
    tick(); start = 1'b0;
    chkb("alu_c1_imem_req", imem_req, 1'b1);
    chk ("alu_c1_imem_addr", {8'h00, imem_addr}, 16'h0010);
    chkb("alu_c1_busy", busy, 1'b1);
    tick();
    chk ("alu_c2_instr", instr, 16'h1123);
    chkb("alu_c2_imem_req", imem_req, 1'b0);
    chkb("alu_c2_alu_en", alu_en, 1'b0);
    tick();
    chkb("alu_c3_alu_en", alu_en, 1'b1);
    chkb("alu_c3_reg_we", reg_we, 1'b0);
    tick();
    chkb("alu_c4_alu_en", alu_en, 1'b0);
    chkb("alu_c4_reg_we", reg_we, 1'b1);
    chk ("alu_c4_pc", {8'h00, pc}, 16'h0010);
    imem_rdata = 16'hE040; zero_flag = 1'b1;
    tick();
    chk ("alu_c5_pc", {8'h00, pc}, 16'h0011);
    chkb("alu_c5_reg_we", reg_we, 1'b0);
    chkb("alu_c5_imem_req", imem_req, 1'b1);

    // Branch taken
    tick();
    chk ("brz_t_instr", instr, 16'hE040);
    chkb("brz_t_dec_alu_en", alu_en, 1'b0);
    tick();
    chk ("brz_t_pc", {8'h00, pc}, 16'h0040);
    chkb("brz_t_alu_en", alu_en, 1'b0);
    chkb("brz_t_reg_we", reg_we, 1'b0);
    chkb("brz_t_imem_req", imem_req, 1'b1);

    // Branch not taken
    zero_flag = 1'b0;
    tick(); tick();
    chk ("brz_nt_pc", {8'h00, pc}, 16'h0041);
    chkb("brz_nt_reg_we", reg_we, 1'b0);

    // Load with one fetch stall and three memory wait cycles
    imem_valid = 1'b0; imem_rdata = 16'hC000;
    tick();
    chkb("ldr_stall_imem_req", imem_req, 1'b1);
    chk ("ldr_stall_instr", instr, 16'hE040);
    imem_valid = 1'b1;
    tick();
    chk ("ldr_instr", instr, 16'hC000);
    imem_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      chkb($sformatf("ldr_m%0d_mem_req", i), mem_req, 1'b1);
      chkb($sformatf("ldr_m%0d_mem_we", i), mem_we, 1'b0);
      chkb($sformatf("ldr_m%0d_reg_we", i), reg_we, 1'b0);
      if (i == 3) mem_ready = 1'b1;
      tick();
    end
    chkb("ldr_wb_mem_req", mem_req, 1'b0);
    chkb("ldr_wb_reg_we", reg_we, 1'b1);
    mem_ready = 1'b0;
    tick();
    chkb("ldr_post_reg_we", reg_we, 1'b0);
    chk ("ldr_pc", {8'h00, pc}, 16'h0042);

    // Store
    imem_valid = 1'b1; imem_rdata = 16'hD000;
    tick(); imem_valid = 1'b0;
    tick();
    chkb("str_mem_req", mem_req, 1'b1);
    chkb("str_mem_we", mem_we, 1'b1);
    mem_ready = 1'b1;
    tick(); mem_ready = 1'b0;
    chkb("str_done_mem_req", mem_req, 1'b0);
    chkb("str_reg_we", reg_we, 1'b0);
    chk ("str_pc", {8'h00, pc}, 16'h0043);
    chkb("str_imem_req", imem_req, 1'b1);

    // Halt
    imem_valid = 1'b1; imem_rdata = 16'hF000;
    tick(); imem_valid = 1'b0;
    tick();
    chkb("halt_done", done, 1'b1);
    chkb("halt_busy", busy, 1'b0);
    chk ("halt_pc", {8'h00, pc}, 16'h0043);
    chkb("halt_imem_req", imem_req, 1'b0);
    tick(); tick();
    chk ("halt_pc_frozen", {8'h00, pc}, 16'h0043);
    chkb("halt_done_held", done, 1'b1);

    // Restart from halt
    start_pc = 8'h00; start = 1'b1;
    tick(); start = 1'b0;
    chkb("restart_done", done, 1'b0);
    chkb("restart_busy", busy, 1'b1);
    chkb("restart_imem_req", imem_req, 1'b1);
    chk ("restart_addr", {8'h00, imem_addr}, 16'h0000);

    // Start while busy is ignored
    start = 1'b1; start_pc = 8'h77;
    tick(); start = 1'b0;
    chk ("busy_start_pc", {8'h00, pc}, 16'h0000);
    chkb("busy_start_imem_req", imem_req, 1'b1);

    // Asynchronous reset during memory wait
    imem_valid = 1'b1; imem_rdata = 16'hC000;
    tick(); imem_valid = 1'b0;
    tick();
    chkb("rstw_mem_req_before", mem_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    chkb("rstw_mem_req", mem_req, 1'b0);
    chk ("rstw_pc", {8'h00, pc}, 16'h0000);
    chkb("rstw_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; mem_ready = 1'b1;
    tick();
    chkb("rstw_late_reg_we0", reg_we, 1'b0);
    tick();
    chkb("rstw_late_reg_we1", reg_we, 1'b0);
    chkb("rstw_late_mem_req", mem_req, 1'b0);
    chkb("rstw_late_busy", busy, 1'b0);
    mem_ready = 1'b0;

    // PC wrap
    start_pc = 8'hFF; start = 1'b1; imem_valid = 1'b1; imem_rdata = 16'h1123;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    chkb("wrap_reg_we", reg_we, 1'b1);
    tick();
    chk ("wrap_pc", {8'h00, pc}, 16'h0000);

    // Halt, then a three-instruction program with two fetch stalls
    imem_rdata = 16'hF000;
    tick(); tick();
    chkb("prog_pre_done", done, 1'b1);
    start_pc = 8'h20; start = 1'b1; imem_valid = 1'b0;
    tick(); start = 1'b0;
    tick();
    imem_valid = 1'b1; imem_rdata = 16'h1123;
    tick(); tick();
    imem_valid = 1'b0;
    tick(); tick(); tick();
    imem_valid = 1'b1;
    tick(); tick(); tick();
    imem_rdata = 16'hF000;
    tick(); tick(); tick();
    chk ("prog_pc", {8'h00, pc}, 16'h0022);
    chkb("prog_done", done, 1'b1);
`ifdef CTRL_PERF_CNT_EN
    chk ("perf_retired", retired_cnt, 16'd3);
    chk ("perf_stall", stall_cnt, 16'd2);
`endif
    imem_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
